// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak slice/lane types and sizes
package keccak_pkg;
    localparam int SLICE_W   = 25;
    localparam int DEPTH     = 64;
    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int IDX_W     = 5;
    localparam int CNT_W     = 6;

    typedef logic [SLICE_W-1:0] slice_t;
    typedef logic [LANE_W-1:0]  lane_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } coll_state_t;
endpackage

// File: rtl/keccak_lane_mux.sv
// rtl/keccak_lane_mux.sv - combinational column select: bit idx of every slice forms one lane
module keccak_lane_mux
    import keccak_pkg::*;
(
    input  slice_t [DEPTH-1:0] slices_i,
    input  logic [IDX_W-1:0]   idx_i,
    output lane_t              lane_o,
    output logic               idx_ok_o
);
    always_comb begin
        lane_o   = '0;
        idx_ok_o = (idx_i < IDX_W'(NUM_LANES));
        if (idx_ok_o) begin
            for (int z = 0; z < DEPTH; z++) begin
                lane_o[z] = slices_i[z][idx_i];
            end
        end
    end
endmodule

// File: rtl/keccak_slice_collector.sv
// rtl/keccak_slice_collector.sv - captures 64 Keccak slices per frame and serves them back as 64-bit lanes
module keccak_slice_collector
    import keccak_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  slice_t           slice_in,
    input  logic             slice_valid,
    input  logic             release_i,
    input  logic             lane_rd,
    input  logic [IDX_W-1:0] lane_idx,
    output lane_t            lane_out,
    output logic             lane_valid,
    output logic             frame_full,
    output logic             busy,
    output logic             overflow,
    output logic             idx_err
);
    localparam cnt_t CNT_LAST = cnt_t'(DEPTH - 1);

    coll_state_t        state_q;
    cnt_t               cnt_q;
    slice_t [DEPTH-1:0] mem_q;
    logic               start_q;
    lane_t              lane_out_q;
    logic               lane_valid_q;
    logic               overflow_q;
    logic               idx_err_q;

    lane_t              mux_lane;
    logic               mux_idx_ok;
    logic               start_rise;

    assign start_rise = start & ~start_q;

    keccak_lane_mux u_lane_mux (
        .slices_i (mem_q),
        .idx_i    (lane_idx),
        .lane_o   (mux_lane),
        .idx_ok_o (mux_idx_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            mem_q        <= '0;
            start_q      <= 1'b0;
            lane_out_q   <= '0;
            lane_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            idx_err_q    <= 1'b0;
        end else begin
            start_q      <= start;
            lane_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (slice_valid) overflow_q <= 1'b1;
                    if (start_rise) begin
                        state_q <= COLLECT;
                        cnt_q   <= '0;
                    end
                end
                COLLECT: begin
                    // start low means the core abandoned the permutation
                    if (!start) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (slice_valid) begin
                        mem_q[cnt_q] <= slice_in;
                        cnt_q        <= cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) state_q <= FULL;
                    end
                end
                FULL: begin
                    if (slice_valid) overflow_q <= 1'b1;
                    if (lane_rd) begin
                        lane_out_q   <= mux_lane;
                        lane_valid_q <= 1'b1;
                        if (!mux_idx_ok) idx_err_q <= 1'b1;
                    end
                    if (release_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign lane_out   = lane_out_q;
    assign lane_valid = lane_valid_q;
    assign frame_full = (state_q == FULL);
    assign busy       = (state_q == COLLECT);
    assign overflow   = overflow_q;
    assign idx_err    = idx_err_q;
endmodule

// File: tb/tb_keccak_slice_collector.sv
// tb/tb_keccak_slice_collector.sv - self-checking bench for keccak_slice_collector
module tb_keccak_slice_collector;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] slice_in;
    logic        slice_valid;
    logic        release_i;
    logic        lane_rd;
    logic [4:0]  lane_idx;
    logic [63:0] lane_out;
    logic        lane_valid;
    logic        frame_full;
    logic        busy;
    logic        overflow;
    logic        idx_err;

    int checks   = 0;
    int failures = 0;
    logic [24:0] exp_mem [64];

    typedef struct {
        int          idx;
        logic [63:0] exp_lane;
        logic        exp_err;
    } vec_t;

    vec_t vecs [27];

    always #5 clk = ~clk;

    keccak_slice_collector dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .slice_in    (slice_in),
        .slice_valid (slice_valid),
        .release_i   (release_i),
        .lane_rd     (lane_rd),
        .lane_idx    (lane_idx),
        .lane_out    (lane_out),
        .lane_valid  (lane_valid),
        .frame_full  (frame_full),
        .busy        (busy),
        .overflow    (overflow),
        .idx_err     (idx_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [63:0] model_lane(input int idx);
        logic [63:0] l;
        l = '0;
        if (idx < 25) begin
            for (int z = 0; z < 64; z++) l[z] = exp_mem[z][idx];
        end
        return l;
    endfunction

    task automatic open_frame();
        start = 1'b0;
        step();
        start = 1'b1;
        step();
    endtask

    task automatic push(input int z, input logic [24:0] s, input int gap);
        exp_mem[z]  = s;
        slice_in    = s;
        slice_valid = 1'b1;
        step();
        slice_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic read_chk(input string name, input int idx, input logic [63:0] exp);
        lane_rd  = 1'b1;
        lane_idx = idx[4:0];
        step();
        lane_rd  = 1'b0;
        chk({name, " lane_out"}, lane_out, exp);
        chk({name, " lane_valid"}, {63'b0, lane_valid}, 64'd1);
    endtask

    task automatic do_release();
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        chk("release frame_full", {63'b0, frame_full}, 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " lane_out"}, lane_out, 64'd0);
        chk({name, " flags"}, {59'b0, lane_valid, frame_full, busy, overflow, idx_err}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{0, 64'h20, 1'b0};
        for (int i = 1; i < 25; i++) vecs[i] = '{i, 64'h0, 1'b0};
        vecs[25] = '{25, 64'h0, 1'b1};
        vecs[26] = '{31, 64'h0, 1'b1};

        rst = 1'b0; start = 1'b0; slice_in = '0; slice_valid = 1'b0;
        release_i = 1'b0; lane_rd = 1'b0; lane_idx = '0;
        repeat (2) step();
        chk_all_zero("reset");
        rst = 1'b1;
        step();

        lane_rd = 1'b1;
        step();
        lane_rd = 1'b0;
        chk("idle lane_rd ignored", {63'b0, lane_valid}, 64'd0);

        // 1: ramp pattern, back-to-back strobes
        open_frame();
        chk("t1 busy", {63'b0, busy}, 64'd1);
        for (int z = 0; z < 64; z++) begin
            if (z == 63) chk("t1 not full before last", {63'b0, frame_full}, 64'd0);
            push(z, 25'(z * 3 + 1), 0);
        end
        chk("t1 frame_full", {63'b0, frame_full}, 64'd1);
        chk("t1 busy cleared", {63'b0, busy}, 64'd0);
        read_chk("t1 lane0", 0, 64'h5555_5555_5555_5555);
        read_chk("t1 lane1", 1, model_lane(1));
        do_release();

        // 2+3: single set bit, back-to-back table reads, bad indices
        open_frame();
        for (int z = 0; z < 64; z++) push(z, (z == 5) ? 25'h1 : 25'h0, 0);
        for (int i = 0; i < 27; i++) begin
            lane_rd  = 1'b1;
            lane_idx = vecs[i].idx[4:0];
            step();
            chk($sformatf("t2 lane_out idx%0d", vecs[i].idx), lane_out, vecs[i].exp_lane);
            chk($sformatf("t2 lane_valid idx%0d", vecs[i].idx), {63'b0, lane_valid}, 64'd1);
            chk($sformatf("t2 idx_err idx%0d", vecs[i].idx), {63'b0, idx_err}, {63'b0, vecs[i].exp_err});
        end
        lane_rd = 1'b0;
        step();
        chk("t2 lane_valid pulse", {63'b0, lane_valid}, 64'd0);
        slice_in = 25'h1FF_FFFF; slice_valid = 1'b1;
        step();
        slice_valid = 1'b0;
        chk("t3 overflow", {63'b0, overflow}, 64'd1);
        read_chk("t3 lane0 unchanged", 0, 64'h20);
        step();
        chk("t3 lane_out holds", lane_out, 64'h20);
        do_release();

        // 4: abort after 30 slices, then a clean frame
        open_frame();
        for (int z = 0; z < 30; z++) push(z, 25'h1AB_CDEF, 0);
        start = 1'b0;
        step();
        chk("t4 abort busy", {63'b0, busy}, 64'd0);
        chk("t4 abort frame_full", {63'b0, frame_full}, 64'd0);
        open_frame();
        for (int z = 0; z < 64; z++) push(z, 25'((z * 7 + 3) ^ (z << 12)), 0);
        chk("t4 frame_full", {63'b0, frame_full}, 64'd1);
        for (int i = 0; i < 25; i++) read_chk($sformatf("t4 lane%0d", i), i, model_lane(i));
        do_release();

        // 5: strobe every third cycle
        open_frame();
        for (int z = 0; z < 64; z++) begin
            if (z == 63) chk("t5 not full before last", {63'b0, frame_full}, 64'd0);
            push(z, 25'(1 << (z % 25)), 2);
        end
        chk("t5 frame_full", {63'b0, frame_full}, 64'd1);
        for (int i = 0; i < 25; i++) read_chk($sformatf("t5 lane%0d", i), i, model_lane(i));
        do_release();

        // 6: asynchronous reset mid-collect and in full
        open_frame();
        for (int z = 0; z < 10; z++) push(z, 25'h155_5555, 0);
        #2 rst = 1'b0;
        #1 chk_all_zero("t6 reset in collect");
        step();
        rst = 1'b1; start = 1'b0;
        step();
        open_frame();
        for (int z = 0; z < 64; z++) push(z, 25'(z * 11 + 5), 0);
        read_chk("t6 lane2", 2, model_lane(2));
        lane_rd = 1'b1; lane_idx = 5'd30;
        step();
        lane_rd = 1'b0;
        chk("t6 idx_err before reset", {63'b0, idx_err}, 64'd1);
        #2 rst = 1'b0;
        #1 chk_all_zero("t6 reset in full");
        step();
        rst = 1'b1; start = 1'b0;
        step();

        slice_valid = 1'b1;
        step();
        slice_valid = 1'b0;
        chk("t6 idle overflow", {63'b0, overflow}, 64'd1);

        open_frame();
        for (int z = 0; z < 64; z++) push(z, 25'((z << 3) ^ 25'h0F0F0F), 0);
        lane_rd = 1'b1; lane_idx = 5'd3; release_i = 1'b1;
        step();
        lane_rd = 1'b0; release_i = 1'b0;
        chk("t6 release+rd lane_out", lane_out, model_lane(3));
        chk("t6 release+rd lane_valid", {63'b0, lane_valid}, 64'd1);
        chk("t6 release frame_full", {63'b0, frame_full}, 64'd0);
        lane_rd = 1'b1;
        step();
        lane_rd = 1'b0;
        chk("t6 idle after release no read", {63'b0, lane_valid}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
